// File: rtl/seq_bit_tx.sv
// seq_bit_tx: serial pattern transmitter.
// On an accepted start it latches a pattern word and shifts the low len bits
// out MSB-first on out_bit, one bit every BIT_DIV clocks. A guard gap of
// GAP_BITS zero bit-periods follows each frame so a downstream sequence
// detector can return to idle. done pulses for one cycle on the first cycle
// back in IDLE.
// Optional build macro SEQ_TX_PARITY_EN appends one even-parity bit after the
// data bits, before the guard gap.
// All outputs are registered. reset is asynchronous and active-low.
module seq_bit_tx #(
  parameter int NBITS    = 8,
  parameter int LEN_W    = 3,
  parameter int BIT_DIV  = 1,
  parameter int GAP_BITS = 2
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             start,
  input  logic [NBITS-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             out_bit,
  output logic             busy,
  output logic             done,
  output logic             bit_strobe
);

  // Divider counts 0..BIT_DIV-1; BIT_DIV=1 leaves a 1-bit counter stuck at 0,
  // so every clock is a wrap and each bit lasts exactly one cycle.
  localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);

  // Gap counter counts 0..GAP_BITS*BIT_DIV-1. With GAP_BITS=0 the GAP state
  // is never entered and the counter stays at 0.
  localparam int GAP_CLKS = GAP_BITS * BIT_DIV;
  localparam int GAP_W    = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
`ifdef SEQ_TX_PARITY_EN
    ,
    S_PAR  = 2'd3
`endif
  } state_t;

  state_t           state,   state_nx;
  logic [NBITS-1:0] shreg,   shreg_nx;
  logic [LEN_W-1:0] idx,     idx_nx;
  logic [DIV_W-1:0] div_cnt, div_nx;
  logic [GAP_W-1:0] gap_cnt, gap_nx;
  logic             out_nx;
  logic             busy_nx;
  logic             done_nx;
  logic             strobe_nx;
  logic [LEN_W-1:0] start_idx;
  logic [LEN_W-1:0] idx_m1;
`ifdef SEQ_TX_PARITY_EN
  logic             parity,  parity_nx;
`endif

  // Index of the first (most significant) bit to send; len=0 means NBITS.
  function automatic logic [LEN_W-1:0] first_idx(input logic [LEN_W-1:0] l);
    if (l == '0)
      return LEN_W'(NBITS - 1);
    else
      return l - 1'b1;
  endfunction

`ifdef SEQ_TX_PARITY_EN
  // Even parity over the low len bits of the word (len=0 means all NBITS).
  function automatic logic frame_parity(input logic [NBITS-1:0] d,
                                        input logic [LEN_W-1:0] l);
    logic p;
    int   n;
    p = 1'b0;
    n = (l == '0) ? NBITS : int'(l);
    for (int i = 0; i < NBITS; i++) begin
      if (i < n)
        p = p ^ d[i];
    end
    return p;
  endfunction
`endif

  assign start_idx = first_idx(len);
  assign idx_m1    = idx - 1'b1;

  // State register and all registered outputs; reset aborts any frame at once.
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      shreg      <= '0;
      idx        <= '0;
      div_cnt    <= '0;
      gap_cnt    <= '0;
      out_bit    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bit_strobe <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      shreg      <= shreg_nx;
      idx        <= idx_nx;
      div_cnt    <= div_nx;
      gap_cnt    <= gap_nx;
      out_bit    <= out_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      bit_strobe <= strobe_nx;
`ifdef SEQ_TX_PARITY_EN
      parity     <= parity_nx;
`endif
    end
  end

  // Next-state and next-output logic; values describe the following cycle.
  always_comb begin
    state_nx  = state;
    shreg_nx  = shreg;
    idx_nx    = idx;
    div_nx    = div_cnt;
    gap_nx    = gap_cnt;
    out_nx    = out_bit;
    busy_nx   = busy;
    done_nx   = 1'b0;
    strobe_nx = 1'b0;
`ifdef SEQ_TX_PARITY_EN
    parity_nx = parity;
`endif

    unique case (state)
      S_IDLE: begin
        out_nx  = 1'b0;
        busy_nx = 1'b0;
        if (start) begin
          // Latch the frame; the first data bit is visible next cycle.
          state_nx  = S_SEND;
          shreg_nx  = pattern;
          idx_nx    = start_idx;
          div_nx    = '0;
          out_nx    = pattern[start_idx];
          busy_nx   = 1'b1;
          strobe_nx = 1'b1;
`ifdef SEQ_TX_PARITY_EN
          parity_nx = frame_parity(pattern, len);
`endif
        end
      end

      S_SEND: begin
        if (div_cnt == DIV_LAST) begin
          div_nx = '0;
          if (idx != '0) begin
            idx_nx    = idx_m1;
            out_nx    = shreg[idx_m1];
            strobe_nx = 1'b1;
          end else begin
`ifdef SEQ_TX_PARITY_EN
            // Last data bit finished: send the parity bit next.
            state_nx  = S_PAR;
            out_nx    = parity;
            strobe_nx = 1'b1;
`else
            if (GAP_CLKS > 0) begin
              state_nx = S_GAP;
              gap_nx   = '0;
              out_nx   = 1'b0;
            end else begin
              state_nx = S_IDLE;
              out_nx   = 1'b0;
              busy_nx  = 1'b0;
              done_nx  = 1'b1;
            end
`endif
          end
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end

`ifdef SEQ_TX_PARITY_EN
      S_PAR: begin
        if (div_cnt == DIV_LAST) begin
          div_nx = '0;
          if (GAP_CLKS > 0) begin
            state_nx = S_GAP;
            gap_nx   = '0;
            out_nx   = 1'b0;
          end else begin
            state_nx = S_IDLE;
            out_nx   = 1'b0;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
          end
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end
`endif

      S_GAP: begin
        out_nx = 1'b0;
        if (gap_cnt == GAP_LAST) begin
          // Guard gap over: first IDLE cycle carries the done pulse.
          state_nx = S_IDLE;
          gap_nx   = '0;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end else begin
          gap_nx = gap_cnt + 1'b1;
        end
      end

      default: begin
        state_nx = S_IDLE;
        out_nx   = 1'b0;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/seq_bit_tx.md
Name: seq_bit_tx

Overview:
Serial pattern transmitter. It is the source side of the serial in_bit stream that the 3-ones sequence detector FSM consumes. On a start request it latches a pattern word and shifts the low len bits out MSB-first on out_bit, one bit per BIT_DIV clocks. It then drives a guard gap of zeros so the downstream detector returns to its idle state between frames. On the board, start, pattern and len come from SWI, and out_bit can be looped back to the detector input.

Parameters:
NBITS, 8, pattern width in bits
LEN_W, 3, len field width; must equal $clog2(NBITS)
BIT_DIV, 1, clocks per transmitted bit (>=1)
GAP_BITS, 2, number of zero bit-periods appended after each frame (>=0)

Ports:
clk_2  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  frame request; level-sampled while IDLE
pattern  input  NBITS  data word; latched on accepted start
len  input  LEN_W  bits to send, 1..NBITS-1; value 0 means NBITS
out_bit  output  1  serial data, registered
busy  output  1  high while a frame or gap is in progress
done  output  1  one-cycle pulse at frame completion
bit_strobe  output  1  one-cycle pulse on the first clock of each transmitted bit (data and parity)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; out_bit=0, busy=0, done=0, bit_strobe=0; all counters and the shift register clear. Reset asserted mid-frame aborts the frame immediately, with no done pulse.
- States: IDLE, SEND, PAR (only with the optional feature), GAP.
- IDLE:
  - out_bit=0, busy=0.
  - On an edge with start=1: latch pattern into shreg and latch len (0 maps to NBITS); bit index = len-1; go to SEND.
  - During the following cycle: out_bit=pattern[len-1], busy=1, bit_strobe=1.
- SEND:
  - Each bit is held for exactly BIT_DIV clocks, counted by a div counter 0..BIT_DIV-1.
  - When the div counter wraps and index>0: decrement index; out_bit=shreg[index-1]; bit_strobe pulses.
  - When the div counter wraps and index==0: go to PAR if enabled, else to GAP when GAP_BITS>0, else to IDLE.
- GAP:
  - out_bit=0, busy=1.
  - Lasts GAP_BITS*BIT_DIV clocks, then go to IDLE.
- Completion: done=1 for exactly the first cycle back in IDLE, and busy=0 in that same cycle.
- Latency: the first data bit appears on out_bit 1 clock after the accepted start edge. Total frame occupancy = (len + parity + GAP_BITS)*BIT_DIV clocks of busy=1.
- Input handling: start is ignored while busy. pattern and len changes during a frame have no effect.
- Back-to-back frames: start=1 held continuously gives back-to-back frames. A start sampled in the done cycle is accepted, so the next frame's first bit appears on the following cycle.
- BIT_DIV=1: the div counter degenerates, one bit per clock, and bit_strobe is high on every busy data cycle.
- Internal counters are sized with $clog2 of their maximum value plus 1; there is no wrap outside the stated ranges.

Optional Feature:
Macro SEQ_TX_PARITY_EN.
- Defined: after the last data bit, state PAR drives one even-parity bit for BIT_DIV clocks, with a bit_strobe pulse. The parity bit is the XOR of the len transmitted bits. The frame then continues to GAP or IDLE as above.
- Undefined: the PAR state and parity logic are absent, and SEND goes directly to GAP or IDLE.

Test Plan:
1. Idle output and end-of-frame timing. Setup: BIT_DIV=1, GAP_BITS=2, pattern=8'h07, len=3; pulse start for 1 cycle at edge E0.
   - Cycles 1-3: out_bit=1,1,1.
   - Cycles 4-5: out_bit=0,0.
   - Cycle 6: done=1, busy=0.
   - Looped into the detector, the detector output is high only while it holds state D, and it clears after gap cycle 4.
2. Bit holding with a divider. Setup: BIT_DIV=3, pattern=8'hA5, len=0 (treated as 8).
   - out_bit shows 1,0,1,0,0,1,0,1, each bit held 3 clocks.
   - bit_strobe pulses 8 times, 3 clocks apart.
   - busy is high for (8+2)*3=30 clocks.
3. Start ignored while busy. Setup: pulse start again at cycle 2 of test 1, with pattern=8'hFF.
   - The frame is unchanged.
   - Exactly one done pulse occurs.
4. Reset mid-frame. Setup: assert reset=0 asynchronously in the middle of bit 2 of test 2.
   - out_bit, busy, done and bit_strobe go to 0 without waiting for a clock edge.
   - No done pulse occurs.
   - After release, a new start=1 sends a full frame normally.
5. Continuous start. Setup: start held at 1, GAP_BITS=0, len=2, pattern=2'b11.
   - out_bit is 1 on every cycle except each done cycle.
   - done pulses every 3 clocks.
6. Parity, with SEQ_TX_PARITY_EN defined. Setup: pattern=8'h07, len=3.
   - The parity bit is 1, giving the sequence 1,1,1,1,0,0.
   - With pattern=8'h03, len=3, the sequence is 0,1,1,0,0,0.
